read_control: RTL and testbench
===============================

READ_CONTROL -- requirements
Module: read_control

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 4, meaning log2 of FIFO depth (depth = 16).
REQ-002 SHALL provide parameter AE_THRESH, default 2, meaning the almost-empty threshold in entries.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: rd_valid  input  1  read request from consumer.
REQ-006 SHALL have port: wr_addr  input  ADDR_WIDTH+1  write pointer from the write side, including wrap bit.
REQ-007 SHALL have port: uf_clr  input  1  clears the sticky underflow flag.
REQ-008 SHALL have port: rd_en  output  1  read-memory strobe.
REQ-009 SHALL have port: rd_addr  output  ADDR_WIDTH+1  read pointer; memory index is rd_addr[ADDR_WIDTH-1:0].
REQ-010 SHALL have port: rd_empty  output  1  FIFO empty flag.
REQ-011 SHALL have port: wr_full  output  1  FIFO full flag, fed to the write side.
REQ-012 SHALL have port: rd_almost_empty  output  1  level <= AE_THRESH.
REQ-013 SHALL have port: rd_level  output  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
REQ-014 SHALL have port: rd_data_valid  output  1  memory read data valid, one cycle after rd_en.
REQ-015 SHALL have port: rd_underflow  output  1  sticky underflow error flag.

Function
REQ-016 rd_en SHALL be combinational: rd_valid AND NOT rd_empty.
REQ-017 rd_addr SHALL be a register that increments by 1 on each clock edge where rd_en=1, holds otherwise, and wraps modulo 2^(ADDR_WIDTH+1).
REQ-018 rd_empty SHALL be combinational: 1 when wr_addr equals rd_addr on all ADDR_WIDTH+1 bits.
REQ-019 wr_full SHALL be combinational: 1 when the pointer MSBs differ and bits [ADDR_WIDTH-1:0] are equal.
REQ-020 rd_level SHALL be combinational (wr_addr - rd_addr) modulo 2^(ADDR_WIDTH+1), and SHALL never exceed 2^ADDR_WIDTH.
REQ-021 rd_almost_empty SHALL be combinational: 1 when rd_level <= AE_THRESH, including the empty case.
REQ-022 rd_data_valid SHALL be a register loaded with rd_en each cycle, giving a fixed latency of 1 cycle from rd_en.
REQ-023 Underflow event SHALL be defined as rd_valid=1 while rd_empty=1. Such a request SHALL be dropped: rd_en=0 and rd_addr unchanged.
REQ-024 rd_underflow SHALL be set on the edge following an underflow event, and SHALL stay set until uf_clr=1. If set and clear coincide, set SHALL win.
REQ-025 Simultaneous write and read (wr_addr increments, rd_en=1) SHALL leave rd_level unchanged on the next cycle.
REQ-026 Empty is judged on current pointers only. A write landing in the same cycle as a read request to an empty FIFO SHALL NOT enable the read; the read is served on the following cycle.
REQ-027 A read while wr_full=1 SHALL be accepted, and wr_full SHALL deassert on the next cycle unless a write coincides.
REQ-028 Pointer wrap (rd_addr 31 -> 0 at ADDR_WIDTH=4) SHALL keep empty, full and level correct.

Reset
REQ-029 On reset_n=0, asynchronously, the block SHALL set rd_addr=0, rd_data_valid=0 and rd_underflow=0. Combinational outputs then follow from wr_addr.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight rd_data_valid. The write side is reset by the same reset_n, so after reset rd_empty=1, rd_level=0 and wr_full=0.
REQ-031 Normal operation SHALL resume on the first rising edge after reset_n deasserts.

Verification
REQ-032 Reset then idle, wr_addr=0 -> rd_empty=1, rd_almost_empty=1, rd_level=0, wr_full=0, rd_addr=0.
REQ-033 wr_addr=5, rd_valid held for 7 cycles -> 5 rd_en pulses, rd_addr=5, rd_data_valid trails each pulse by 1 cycle, rd_underflow=1 from the 6th request, rd_empty=1.
REQ-034 wr_addr=16, rd_addr=0 -> wr_full=1, rd_level=16. One read -> wr_full=0, rd_level=15.
REQ-035 Pointer wrap: rd_addr=30, wr_addr=1 -> rd_level=3 and rd_almost_empty=0. Three reads -> rd_addr=1, rd_empty=1, rd_almost_empty=1.
REQ-036 Concurrent traffic: write and read every cycle at rd_level=4 -> rd_level stays 4. Assert uf_clr after an underflow -> rd_underflow=0 on the next cycle.
REQ-037 Assert reset_n=0 in the cycle after an rd_en -> rd_data_valid=0 immediately and rd_addr=0.

Source files
------------

// File: rtl/read_control.sv
// Read-side pointer and flag logic for a dual-pointer FIFO. The wrap bit on
// each pointer tells full from empty; rd_underflow stays set until uf_clr.
module read_control #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic                  uf_clr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH:0]   rd_addr,
  output logic                  rd_empty,
  output logic                  wr_full,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_data_valid,
  output logic                  rd_underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] level_raw;
  logic                uf_event;

  assign rd_empty  = (wr_addr == rd_addr);
  assign wr_full   = (wr_addr[ADDR_WIDTH] != rd_addr[ADDR_WIDTH]) &&
                     (wr_addr[ADDR_WIDTH-1:0] == rd_addr[ADDR_WIDTH-1:0]);
  assign level_raw = wr_addr - rd_addr;
  // Clamp guards against an out-of-range write pointer ever reporting > depth.
  assign rd_level  = (level_raw > DEPTH) ? DEPTH : level_raw;
  assign rd_almost_empty = (rd_level <= AE_LVL);
  assign rd_en     = rd_valid && !rd_empty;
  assign uf_event  = rd_valid && rd_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr       <= '0;
      rd_data_valid <= 1'b0;
      rd_underflow  <= 1'b0;
    end else begin
      if (rd_en) rd_addr <= rd_addr + ONE;
      rd_data_valid <= rd_en;
      // Set has priority over clear so a coincident event is never lost.
      if (uf_event)    rd_underflow <= 1'b1;
      else if (uf_clr) rd_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_control.sv
// Directed bench for read_control: an occupancy-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_read_control;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_valid;
  logic [AW:0]   wr_addr;
  logic          uf_clr;
  logic          rd_en;
  logic [AW:0]   rd_addr;
  logic          rd_empty;
  logic          wr_full;
  logic          rd_almost_empty;
  logic [AW:0]   rd_level;
  logic          rd_data_valid;
  logic          rd_underflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // reference state: number of entries consumed so far, last-cycle grant, sticky error
  int m_rd  = 0;
  int m_dv  = 0;
  int m_uf  = 0;

  read_control #(.ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .wr_addr(wr_addr),
    .uf_clr(uf_clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_empty(rd_empty),
    .wr_full(wr_full), .rd_almost_empty(rd_almost_empty), .rd_level(rd_level),
    .rd_data_valid(rd_data_valid), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  function automatic int occ();
    return (int'(wr_addr) - m_rd + PMOD) % PMOD;
  endfunction

  function automatic int exp_level();
    return (occ() > DEPTH) ? DEPTH : occ();
  endfunction

  function automatic int exp_grant();
    return (rd_valid && occ() != 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rd = 0; m_dv = 0; m_uf = 0;
    end else begin
      int g;
      g = exp_grant();
      if (rd_valid && occ() == 0) m_uf = 1;
      else if (uf_clr)            m_uf = 0;
      m_rd = (m_rd + g) % PMOD;
      m_dv = g;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_rd_addr",   int'(rd_addr), m_rd);
      check("m_empty",     int'(rd_empty), (occ() == 0) ? 1 : 0);
      check("m_full",      int'(wr_full), (occ() == DEPTH) ? 1 : 0);
      check("m_level",     int'(rd_level), exp_level());
      check("m_ae",        int'(rd_almost_empty), (exp_level() <= AE) ? 1 : 0);
      check("m_rd_en",     int'(rd_en), exp_grant());
      check("m_dvalid",    int'(rd_data_valid), m_dv);
      check("m_underflow", int'(rd_underflow), m_uf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rd_valid = 1'b0; uf_clr = 1'b0; wr_addr = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; rd_valid = 1'b0; uf_clr = 1'b0; wr_addr = '0;
    #2;
    chk_on = 1'b1;
    do_reset();

    // idle after reset
    @(negedge clk);
    check("rst_empty", int'(rd_empty), 1);
    check("rst_ae",    int'(rd_almost_empty), 1);
    check("rst_level", int'(rd_level), 0);
    check("rst_full",  int'(wr_full), 0);
    check("rst_addr",  int'(rd_addr), 0);
    tick();

    // five entries, seven requests
    wr_addr = 5'd5; rd_valid = 1'b1; pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (rd_en) pulses++;
      check("drain_en", int'(rd_en), (i <= 5) ? 1 : 0);
      check("drain_uf", int'(rd_underflow), (i >= 7) ? 1 : 0);
      tick();
    end
    rd_valid = 1'b0;
    @(negedge clk);
    check("drain_pulses", pulses, 5);
    check("drain_addr",   int'(rd_addr), 5);
    check("drain_empty",  int'(rd_empty), 1);
    check("drain_uf_hold", int'(rd_underflow), 1);
    tick();

    uf_clr = 1'b1;
    @(negedge clk);
    check("clr_same_cycle", int'(rd_underflow), 1);
    tick();
    uf_clr = 1'b0;
    @(negedge clk);
    check("clr_next_cycle", int'(rd_underflow), 0);
    tick();

    // set and clear together: set wins
    rd_valid = 1'b1; uf_clr = 1'b1;
    tick();
    rd_valid = 1'b0; uf_clr = 1'b0;
    @(negedge clk);
    check("set_wins", int'(rd_underflow), 1);
    tick();

    // full boundary
    do_reset();
    wr_addr = 5'd16;
    @(negedge clk);
    check("full_flag",  int'(wr_full), 1);
    check("full_level", int'(rd_level), 16);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("full_rel_flag",  int'(wr_full), 0);
    check("full_rel_level", int'(rd_level), 15);
    tick();

    // concurrent traffic at level 4, walking rd_addr up to 26
    do_reset();
    wr_addr = 5'd4; rd_valid = 1'b1;
    @(negedge clk);
    check("conc_level0", int'(rd_level), 4);
    for (int i = 0; i < 26; i++) begin
      tick();
      wr_addr = wr_addr + 5'd1;
      @(negedge clk);
      check("conc_level", int'(rd_level), 4);
    end
    repeat (4) tick();
    rd_valid = 1'b0;

    // pointer wrap
    wr_addr = 5'd1;
    @(negedge clk);
    check("wrap_addr0", int'(rd_addr), 30);
    check("wrap_level", int'(rd_level), 3);
    check("wrap_ae",    int'(rd_almost_empty), 0);
    tick();
    rd_valid = 1'b1;
    repeat (3) tick();
    rd_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr",  int'(rd_addr), 1);
    check("wrap_empty", int'(rd_empty), 1);
    check("wrap_ae2",   int'(rd_almost_empty), 1);
    tick();

    // write landing with a request to an empty FIFO
    rd_valid = 1'b1;
    @(negedge clk);
    check("land_en0", int'(rd_en), 0);
    tick();
    wr_addr = 5'd2;
    @(negedge clk);
    check("land_en1", int'(rd_en), 1);
    tick();
    rd_valid = 1'b0; uf_clr = 1'b1;
    tick();
    uf_clr = 1'b0;

    // reset right after a grant
    wr_addr = 5'd5;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    check("pre_rst_dv", int'(rd_data_valid), 1);
    #1;
    reset_n = 1'b0; wr_addr = '0;
    #1;
    check("mid_rst_dv",   int'(rd_data_valid), 0);
    check("mid_rst_addr", int'(rd_addr), 0);
    check("mid_rst_empty", int'(rd_empty), 1);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
